// File: rtl/circuit1_seq_if.sv
// circuit1_seq_if: operand/result handshake bundle for circuit1_seq (ovf present only with C1_SEQ_OVF_EN)
interface circuit1_seq_if #(parameter int DATAWIDTH = 8);
    logic                     start;
    logic                     ready;
    logic                     done;
    logic [DATAWIDTH-1:0]     a;
    logic [DATAWIDTH-1:0]     b;
    logic [DATAWIDTH-1:0]     c;
    logic [DATAWIDTH-1:0]     z;
    logic [2*DATAWIDTH-1:0]   x;
`ifdef C1_SEQ_OVF_EN
    logic                     ovf;
    modport master (output start, a, b, c, input ready, done, x, z, ovf);
    modport slave  (input start, a, b, c, output ready, done, x, z, ovf);
`else
    modport master (output start, a, b, c, input ready, done, x, z);
    modport slave  (input start, a, b, c, output ready, done, x, z);
`endif
endinterface

// File: rtl/circuit1_seq.sv
// circuit1_seq: x = a*c - (a+b), z = min(a+b, a+c) on one shared add/sub unit; C1_SEQ_OVF_EN adds ovf
module circuit1_seq #(
    parameter int DATAWIDTH = 8
) (
    input logic           Clk,
    input logic           Rst,
    circuit1_seq_if.slave bus
);
    localparam int W = DATAWIDTH;
`ifdef C1_SEQ_OVF_EN
    localparam int SW = 2*W + 1;
`else
    localparam int SW = 2*W;
`endif
    typedef enum logic [1:0] {IDLE, S_D, S_E, S_X} state_t;
    state_t          state, state_nx;
    logic [W-1:0]    ra, rb, rc, d, e, z_r;
    logic [2*W-1:0]  f, x_r, prod;
    logic [SW-1:0]   op_a, op_b, sum;
    logic            sub, done_r;
`ifdef C1_SEQ_OVF_EN
    logic            cd, ce, ovf_r;
`endif
    // state register; reset discards any in-flight operation
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= IDLE;
        else      state <= state_nx;
    end
    // next state: accept only in IDLE, then walk D -> E -> X -> IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? S_D : IDLE;
            S_D:     state_nx = S_E;
            S_E:     state_nx = S_X;
            default: state_nx = IDLE;
        endcase
    end
    // shared adder operand mux: a+b, then a+c, then f-d
    always_comb begin
        op_a = SW'(ra);
        op_b = SW'(rb);
        sub  = 1'b0;
        if (state == S_E) op_b = SW'(rc);
        if (state == S_X) begin
            op_a = SW'(f);
            op_b = SW'(d);
            sub  = 1'b1;
        end
    end
    assign sum  = sub ? op_a - op_b : op_a + op_b;
    assign prod = ra * rc;
    // datapath registers; x/z only change at the final step so partial results stay hidden
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ra <= '0; rb <= '0; rc <= '0;
            d <= '0; e <= '0; f <= '0;
            x_r <= '0; z_r <= '0; done_r <= 1'b0;
`ifdef C1_SEQ_OVF_EN
            cd <= 1'b0; ce <= 1'b0; ovf_r <= 1'b0;
`endif
        end else begin
            done_r <= (state == S_X);
            if (state == IDLE && bus.start) begin
                ra <= bus.a;
                rb <= bus.b;
                rc <= bus.c;
            end
            if (state == S_D) begin
                d <= sum[W-1:0];
                f <= prod;
`ifdef C1_SEQ_OVF_EN
                cd <= sum[W];
`endif
            end
            if (state == S_E) begin
                e <= sum[W-1:0];
`ifdef C1_SEQ_OVF_EN
                ce <= sum[W];
`endif
            end
            if (state == S_X) begin
                x_r <= sum[2*W-1:0];
                z_r <= (d > e) ? e : d;
`ifdef C1_SEQ_OVF_EN
                ovf_r <= cd | ce | sum[2*W];
`endif
            end
        end
    end
    assign bus.ready = (state == IDLE);
    assign bus.done  = done_r;
    assign bus.x     = x_r;
    assign bus.z     = z_r;
`ifdef C1_SEQ_OVF_EN
    assign bus.ovf   = ovf_r;
`endif
endmodule
